// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared types and sizes for the 16-way round-robin arbiter.
package dec_arb_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [N_REQ-1:0] req_vec_t;

endpackage

// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the requesting agents and the arbiter.
interface decoder_rr_arbiter_if
  import dec_arb_pkg::*;
;

  req_vec_t req;          // level-held by each requester until done
  req_vec_t grant;        // one-hot grant, zero when no owner
  idx_t     grant_idx;    // current owner
  logic     grant_valid;  // an owner exists

  // Requesting agents drive req and observe the grant.
  modport master (
    output req,
    input  grant,
    input  grant_idx,
    input  grant_valid
  );

  // The arbiter observes req and drives the grant.
  modport slave (
    input  req,
    output grant,
    output grant_idx,
    output grant_valid
  );

endinterface

// File: rtl/decoder4to16.sv
// Plain 4-to-16 one-hot decoder: exactly one output bit set for any input.
module decoder4to16 (
  input  logic [3:0]  data_in,
  output logic [15:0] data_out
);

  assign data_out = 16'h0001 << data_in;

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for 16 requesters with bounded hold time and a
// single turnaround cycle after every release. The owner is kept as an
// index and expanded to a one-hot grant through decoder4to16.
module decoder_rr_arbiter
  import dec_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8  // max consecutive grant cycles; 0 = unlimited
) (
  input  logic                  clk,
  input  logic                  rst_n,
  decoder_rr_arbiter_if.slave   bus
);

  // Hold counter wide enough to reach MAX_HOLD; one bit when unlimited.
  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  typedef logic [HOLD_W-1:0] hold_t;

  localparam hold_t HOLD_MAX = hold_t'(MAX_HOLD);
  localparam hold_t HOLD_SAT = '1;

  arb_state_t state;
  idx_t       grant_idx_q;
  logic       grant_valid_q;
  idx_t       last_idx;
  hold_t      hold_cnt;
  req_vec_t   dec_out;

  // Rotate req so the slot after last_idx lands at bit 0, take the lowest
  // set bit, then undo the rotation. last_idx itself ends up at bit 15,
  // which gives the previous owner the lowest priority.
  function automatic idx_t pick_winner(input req_vec_t r, input idx_t last);
    idx_t     start;
    idx_t     off;
    req_vec_t rot;
    start = last + idx_t'(1);
    rot   = req_vec_t'({r, r} >> start);
    off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = idx_t'(i);
    end
    return start + off;
  endfunction

  // Arbitration FSM: pick an owner from IDLE, hold it in GRANT until it
  // drops its request or uses up its hold budget, then spend one IDLE cycle.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      last_idx      <= '1;
      hold_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            grant_idx_q   <= pick_winner(bus.req, last_idx);
            grant_valid_q <= 1'b1;
            hold_cnt      <= hold_t'(1);
            state         <= GRANT;
          end
        end
        GRANT: begin
          if (!bus.req[grant_idx_q] ||
              (MAX_HOLD != 0 && hold_cnt == HOLD_MAX)) begin
            // Voluntary or forced release; the owner moves to the back.
            grant_valid_q <= 1'b0;
            last_idx      <= grant_idx_q;
            state         <= IDLE;
          end else if (hold_cnt != HOLD_SAT) begin
            // Saturate so an unlimited hold never wraps.
            hold_cnt <= hold_cnt + hold_t'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  decoder4to16 u_dec (
    .data_in  (grant_idx_q),
    .data_out (dec_out)
  );

  // Gate the decoded index so no bit is set while nobody owns the resource.
  assign bus.grant       = dec_out & {N_REQ{grant_valid_q}};
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;

endmodule
